// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller bus: pc register, instruction memory, decode hand-off and control.
// master = the fetch controller, slave = the surrounding datapath/memory/decode.
interface pc_fetch_ctrl_if #(
    parameter int COUNT_W = 32
);
    logic [31:0]        pc_out;
    logic               pc_write;
    logic [31:0]        pc_in;
    logic               imem_req;
    logic [31:0]        imem_addr;
    logic               imem_ready;
    logic [31:0]        imem_rdata;
    logic               instr_valid;
    logic [31:0]        instr_data;
    logic [31:0]        instr_pc;
    logic               dec_ready;
    logic               redirect_valid;
    logic [31:0]        redirect_target;
    logic               halt_req;
    logic               resume;
    logic               misalign_trap;
    logic [COUNT_W-1:0] instr_count;

    modport master (
        input  pc_out, imem_ready, imem_rdata, dec_ready,
               redirect_valid, redirect_target, halt_req, resume,
        output pc_write, pc_in, imem_req, imem_addr, instr_valid,
               instr_data, instr_pc, misalign_trap, instr_count
    );

    modport slave (
        output pc_out, imem_ready, imem_rdata, dec_ready,
               redirect_valid, redirect_target, halt_req, resume,
        input  pc_write, pc_in, imem_req, imem_addr, instr_valid,
               instr_data, instr_pc, misalign_trap, instr_count
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC fetch sequencer: fetch (>=1 cycle, stalls on imem_ready) then hold for decode (stalls on dec_ready).
// PC updates only in BOOT and on the decode handshake; 2 cycles/instr at best.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
    parameter int          COUNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    pc_fetch_ctrl_if.master   io_bus
);

    typedef enum logic [1:0] {
        S_BOOT     = 2'd0,
        S_FETCH    = 2'd1,
        S_WAIT_DEC = 2'd2,
        S_HALTED   = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_imem_req;
    logic                 r_instr_valid;
    logic [31:0]          r_instr_data;
    logic [31:0]          r_instr_pc;
    logic                 r_misalign_trap;
    logic [COUNT_W-1:0]   r_instr_count;

    logic                 w_handshake;
    logic                 w_misaligned;
    logic [31:0]          w_next_pc;

    assign w_handshake  = (r_state == S_WAIT_DEC) && io_bus.dec_ready;
    assign w_misaligned = io_bus.redirect_valid && (io_bus.redirect_target[1:0] != 2'b00);

    always_comb begin
        w_next_pc = io_bus.pc_out + 32'd4;
        if (io_bus.redirect_valid) begin
            w_next_pc = w_misaligned ? TRAP_VECTOR : io_bus.redirect_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_BOOT;
            r_imem_req      <= 1'b0;
            r_instr_valid   <= 1'b0;
            r_instr_data    <= 32'h0;
            r_instr_pc      <= 32'h0;
            r_misalign_trap <= 1'b0;
            r_instr_count   <= '0;
        end else begin
            r_misalign_trap <= 1'b0;
            case (r_state)
                S_BOOT: begin
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (io_bus.imem_ready) begin
                        r_instr_data  <= io_bus.imem_rdata;
                        r_instr_pc    <= io_bus.pc_out;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_WAIT_DEC;
                    end
                end
                S_WAIT_DEC: begin
                    if (io_bus.dec_ready) begin
                        r_instr_count   <= r_instr_count + 1'b1;
                        r_misalign_trap <= w_misaligned;
                        r_instr_valid   <= 1'b0;
                        // halt wins over any resume seen on the same cycle
                        r_imem_req      <= !io_bus.halt_req;
                        r_state         <= io_bus.halt_req ? S_HALTED : S_FETCH;
                    end
                end
                S_HALTED: begin
                    if (io_bus.resume) begin
                        r_imem_req <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                default: begin
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_state       <= S_BOOT;
                end
            endcase
        end
    end

    // BOOT is also the reset state, so its pc load is masked while rst is held.
    assign io_bus.pc_write      = ((r_state == S_BOOT) && !rst) || w_handshake;
    assign io_bus.pc_in         = w_handshake ? w_next_pc : RESET_VECTOR;
    assign io_bus.imem_req      = r_imem_req;
    assign io_bus.imem_addr     = io_bus.pc_out;
    assign io_bus.instr_valid   = r_instr_valid;
    assign io_bus.instr_data    = r_instr_data;
    assign io_bus.instr_pc      = r_instr_pc;
    assign io_bus.misalign_trap = r_misalign_trap;
    assign io_bus.instr_count   = r_instr_count;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios then random traffic against a transaction-level model.
module tb_pc_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] tb_pc = 32'h0;
    int          checks = 0;
    int          errors = 0;

    // model of the fetch stream
    logic [31:0] m_pc;
    logic        m_have;
    logic        m_halted;
    logic        m_trap;
    logic [31:0] m_data;
    logic [31:0] m_ipc;
    int unsigned m_count;

    always #5 clk = ~clk;

    pc_fetch_ctrl_if #(.COUNT_W(32)) bus();

    pc_fetch_ctrl #(
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0080),
        .COUNT_W     (32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_bus(bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // external pc register
    always @(posedge clk) if (bus.pc_write) tb_pc <= bus.pc_in;
    assign bus.pc_out     = tb_pc;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic chk_reset();
        chk("rst_pc_write", bus.pc_write, 1'b0);
        chk("rst_pc_in", bus.pc_in, 32'h0);
        chk("rst_imem_req", bus.imem_req, 1'b0);
        chk("rst_instr_valid", bus.instr_valid, 1'b0);
        chk("rst_instr_data", bus.instr_data, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        chk("rst_trap", bus.misalign_trap, 1'b0);
        chk("rst_count", bus.instr_count, 32'h0);
    endtask

    task automatic chk_boot();
        chk("boot_pc_write", bus.pc_write, 1'b1);
        chk("boot_pc_in", bus.pc_in, 32'h0);
        chk("boot_imem_req", bus.imem_req, 1'b0);
    endtask

    task automatic model_restart();
        m_pc = 32'h0; m_have = 1'b0; m_halted = 1'b0; m_trap = 1'b0; m_count = 0;
    endtask

    // One cycle: check at the negedge, advance the model, return just after the posedge.
    task automatic step();
        logic        hs;
        logic [31:0] nxt;
        @(negedge clk);
        hs = m_have && bus.dec_ready;
        chk("instr_valid", bus.instr_valid, m_have);
        chk("imem_req", bus.imem_req, (!m_have && !m_halted));
        chk("pc_write", bus.pc_write, hs);
        chk("misalign_trap", bus.misalign_trap, m_trap);
        chk("instr_count", bus.instr_count, m_count);
        chk("pc_out", bus.pc_out, m_pc);
        if (m_have) begin
            chk("instr_data", bus.instr_data, m_data);
            chk("instr_pc", bus.instr_pc, m_ipc);
        end else if (!m_halted) begin
            chk("imem_addr", bus.imem_addr, m_pc);
        end
        m_trap = 1'b0;
        if (hs) begin
            if (bus.redirect_valid && bus.redirect_target[1:0] != 2'b00) begin
                nxt = 32'h80;
                m_trap = 1'b1;
            end else if (bus.redirect_valid) begin
                nxt = bus.redirect_target;
            end else begin
                nxt = m_pc + 32'd4;
            end
            chk("pc_in", bus.pc_in, nxt);
            m_pc = nxt;
            m_count++;
            m_have = 1'b0;
            m_halted = bus.halt_req;
        end else if (m_halted) begin
            if (bus.resume) m_halted = 1'b0;
        end else if (!m_have && bus.imem_ready) begin
            m_have = 1'b1;
            m_data = mem_word(m_pc);
            m_ipc  = m_pc;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.imem_ready = 1'b0; bus.dec_ready = 1'b0; bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'h0; bus.halt_req = 1'b0; bus.resume = 1'b0;
        model_restart();

        // reset and boot
        #3 chk_reset();
        #9 rst = 1'b0;
        #1 chk_boot();
        @(posedge clk); #1;

        // streaming with zero-wait memory and ready decode
        bus.imem_ready = 1'b1; bus.dec_ready = 1'b1;
        repeat (6) step();
        chk("count_after_3", bus.instr_count, 32'd3);
        step();

        // decode stall at 0xC
        bus.dec_ready = 1'b0;
        repeat (3) begin
            step();
            chk("stall_valid", bus.instr_valid, 1'b1);
            chk("stall_instr_pc", bus.instr_pc, 32'hC);
            chk("stall_instr_data", bus.instr_data, mem_word(32'hC));
            chk("stall_pc_write", bus.pc_write, 1'b0);
            chk("stall_pc_out", bus.pc_out, 32'hC);
        end

        // aligned redirects
        bus.dec_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h104;
        step();
        bus.redirect_valid = 1'b0;
        chk("redir_104", bus.pc_out, 32'h104);
        step();
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'h0;
        step();
        bus.redirect_valid = 1'b0;
        chk("redir_0", bus.pc_out, 32'h0);

        // misaligned redirect traps
        step();
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'h102;
        step();
        bus.redirect_valid = 1'b0;
        chk("trap_pc", bus.pc_out, 32'h80);
        chk("trap_pulse", bus.misalign_trap, 1'b1);
        step();
        chk("trap_one_cycle", bus.misalign_trap, 1'b0);

        // pc wrap
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        step();
        step();
        chk("pc_wrap", bus.pc_out, 32'h0);

        // halt / resume
        step();
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        repeat (5) step();
        chk("halt_pc_held", bus.pc_out, 32'h4);
        bus.resume = 1'b1;
        step();
        bus.resume = 1'b0; bus.imem_ready = 1'b0;
        step();

        // reset mid-fetch
        rst = 1'b1;
        #1 chk_reset();
        #2 rst = 1'b0;
        #1 chk_boot();
        @(posedge clk); #1;
        model_restart();
        bus.imem_ready = 1'b1;
        step();

        // random traffic
        repeat (800) begin
            bus.imem_ready     = ($urandom_range(3) != 0);
            bus.dec_ready      = ($urandom_range(2) != 0);
            bus.redirect_valid = ($urandom_range(3) == 0);
            case ($urandom_range(7))
                0:       bus.redirect_target = 32'hFFFF_FFFC;
                1, 2:    bus.redirect_target = $urandom;
                default: bus.redirect_target = {$urandom_range(32'h3FFF), 2'b00};
            endcase
            bus.halt_req = ($urandom_range(7) == 0);
            bus.resume   = ($urandom_range(3) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
